// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler for floors 0..7 with SCAN-style direction preference.
// Optional door-reopen input is enabled by defining ELEVATOR_DOOR_REOPEN_EN.
module elevator_scheduler #(
   parameter int unsigned FLOOR_CYCLES = 200,
   parameter int unsigned DOOR_CYCLES  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] up,
   input  logic [7:0] down,
   input  logic [7:0] elevator_btn,
`ifdef ELEVATOR_DOOR_REOPEN_EN
   input  logic       door_btn,
`endif
   output logic [2:0] floor,
   output logic [3:0] status,
   output logic       nextup,
   output logic       nextdown,
   output logic       door_open
);

   localparam int unsigned TravelW = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
   localparam int unsigned DoorW   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TravelW-1:0] TravelLast = TravelW'(FLOOR_CYCLES - 1);
   localparam logic [DoorW-1:0]   DoorLast   = DoorW'(DOOR_CYCLES - 1);

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StMoveUp   = 4'd1,
      StMoveDown = 4'd2,
      StService  = 4'd7,
      StClose    = 4'd8
   } state_e;

   state_e               state_q, state_d;
   logic [2:0]           floor_q, floor_d;
   logic                 dir_up_q, dir_up_d;
   logic [TravelW-1:0]   travel_q, travel_d;
   logic [DoorW-1:0]     door_q, door_d;

   logic [7:0] req;
   logic       here, above, below;
   logic       reopen;
   logic [2:0] arr_floor;
   logic       arr_stop, arr_more, arr_here;

   function automatic logic any_above(input logic [7:0] r, input logic [2:0] f);
      return |(r & (8'hFE << f));
   endfunction

   function automatic logic any_below(input logic [7:0] r, input logic [2:0] f);
      return |(r & ~(8'hFF << f));
   endfunction

   assign req   = up | down | elevator_btn;
   assign here  = req[floor_q];
   assign above = any_above(req, floor_q);
   assign below = any_below(req, floor_q);

`ifdef ELEVATOR_DOOR_REOPEN_EN
   assign reopen = door_btn;
`else
   assign reopen = 1'b0;
`endif

   // Evaluation of the floor the car is about to reach; saturates at 0 and 7.
   always_comb begin
      arr_floor = floor_q;
      arr_stop  = 1'b0;
      arr_more  = 1'b0;
      if (state_q == StMoveDown) begin
         if (floor_q != 3'd0) arr_floor = floor_q - 3'd1;
         arr_stop = elevator_btn[arr_floor] | down[arr_floor];
         arr_more = any_below(req, arr_floor);
      end else begin
         if (floor_q != 3'd7) arr_floor = floor_q + 3'd1;
         arr_stop = elevator_btn[arr_floor] | up[arr_floor];
         arr_more = any_above(req, arr_floor);
      end
      arr_here = req[arr_floor];
   end

   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      dir_up_d = dir_up_q;
      travel_d = travel_q;
      door_d   = door_q;
      unique case (state_q)
         StIdle: begin
            if (here) begin
               state_d = StService;
               door_d  = '0;
            end else if (above) begin
               state_d  = StMoveUp;
               dir_up_d = 1'b1;
               travel_d = '0;
            end else if (below) begin
               state_d  = StMoveDown;
               dir_up_d = 1'b0;
               travel_d = '0;
            end
         end
         StMoveUp, StMoveDown: begin
            if (travel_q == TravelLast) begin
               travel_d = '0;
               floor_d  = arr_floor;
               if (arr_stop) begin
                  state_d = StService;
                  door_d  = '0;
               end else if (!arr_more) begin
                  state_d = arr_here ? StService : StIdle;
                  door_d  = '0;
               end
            end else begin
               travel_d = travel_q + 1'b1;
            end
         end
         StService: begin
            if (reopen) begin
               door_d = '0;
            end else if (door_q == DoorLast) begin
               state_d = StClose;
               door_d  = '0;
            end else begin
               door_d = door_q + 1'b1;
            end
         end
         StClose: begin
            travel_d = '0;
            door_d   = '0;
            // Keep the current sweep direction when it still has work, else reverse.
            if (reopen) begin
               state_d = StService;
            end else if (dir_up_q && above) begin
               state_d = StMoveUp;
            end else if (!dir_up_q && below) begin
               state_d = StMoveDown;
            end else if (below) begin
               state_d  = StMoveDown;
               dir_up_d = 1'b0;
            end else if (above) begin
               state_d  = StMoveUp;
               dir_up_d = 1'b1;
            end else if (here) begin
               state_d = StService;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         floor_q  <= 3'd0;
         dir_up_q <= 1'b1;
         travel_q <= '0;
         door_q   <= '0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         dir_up_q <= dir_up_d;
         travel_q <= travel_d;
         door_q   <= door_d;
      end
   end

   always_comb begin
      nextup   = 1'b0;
      nextdown = 1'b0;
      if (state_q == StService) begin
         if (dir_up_q) begin
            nextup   = above;
            nextdown = ~above & below;
         end else begin
            nextdown = below;
            nextup   = ~below & above;
         end
      end
   end

   assign floor     = floor_q;
   assign status    = state_q;
   assign door_open = (state_q == StService);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls, all checked
// every cycle against a segment-level reference model (defines ELEVATOR_DOOR_REOPEN_EN optional).
module tb_elevator_scheduler;

   localparam int unsigned FC = 4;
   localparam int unsigned DC = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] up = 8'h00;
   logic [7:0] down = 8'h00;
   logic [7:0] elevator_btn = 8'h00;
`ifdef ELEVATOR_DOOR_REOPEN_EN
   logic       door_btn = 1'b0;
`endif
   logic [2:0] floor;
   logic [3:0] status;
   logic       nextup, nextdown, door_open;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: mode uses the status codes, m_left counts cycles left in a segment.
   int m_mode, m_floor, m_left;
   bit m_dir_up;

   always #5 clk = ~clk;

   elevator_scheduler #(
      .FLOOR_CYCLES(FC),
      .DOOR_CYCLES (DC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .up          (up),
      .down        (down),
      .elevator_btn(elevator_btn),
`ifdef ELEVATOR_DOOR_REOPEN_EN
      .door_btn    (door_btn),
`endif
      .floor       (floor),
      .status      (status),
      .nextup      (nextup),
      .nextdown    (nextdown),
      .door_open   (door_open)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit has_above(input logic [7:0] r, input int f);
      for (int i = f + 1; i < 8; i++) if (r[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit has_below(input logic [7:0] r, input int f);
      for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_floor = 0; m_left = 0; m_dir_up = 1'b1;
   endtask

   task automatic enter(input int mode);
      m_mode = mode;
      m_left = (mode == 7) ? DC : FC;
   endtask

   task automatic model_step();
      logic [7:0] r;
      bit btn;
      r = up | down | elevator_btn;
`ifdef ELEVATOR_DOOR_REOPEN_EN
      btn = door_btn;
`else
      btn = 1'b0;
`endif
      case (m_mode)
         0: begin
            if (r[m_floor]) enter(7);
            else if (has_above(r, m_floor)) begin m_dir_up = 1'b1; enter(1); end
            else if (has_below(r, m_floor)) begin m_dir_up = 1'b0; enter(2); end
         end
         1, 2: begin
            m_left--;
            if (m_left == 0) begin
               m_floor += (m_mode == 1) ? 1 : -1;
               if (m_mode == 1 && (elevator_btn[m_floor] || up[m_floor])) enter(7);
               else if (m_mode == 2 && (elevator_btn[m_floor] || down[m_floor])) enter(7);
               else if (m_mode == 1 && !has_above(r, m_floor)) enter(r[m_floor] ? 7 : 0);
               else if (m_mode == 2 && !has_below(r, m_floor)) enter(r[m_floor] ? 7 : 0);
               else m_left = FC;
            end
         end
         7: begin
            if (btn) m_left = DC;
            else begin
               m_left--;
               if (m_left == 0) m_mode = 8;
            end
         end
         default: begin
            if (btn) enter(7);
            else if (m_dir_up && has_above(r, m_floor)) enter(1);
            else if (!m_dir_up && has_below(r, m_floor)) enter(2);
            else if (has_below(r, m_floor)) begin m_dir_up = 1'b0; enter(2); end
            else if (has_above(r, m_floor)) begin m_dir_up = 1'b1; enter(1); end
            else if (r[m_floor]) enter(7);
            else m_mode = 0;
         end
      endcase
   endtask

   task automatic compare_outputs();
      logic [7:0] r;
      bit a, b, nu, nd;
      r = up | down | elevator_btn;
      a = has_above(r, m_floor);
      b = has_below(r, m_floor);
      nu = 1'b0; nd = 1'b0;
      if (m_mode == 7) begin
         if (m_dir_up) begin nu = a; nd = !a && b; end
         else begin nd = b; nu = !b && a; end
      end
      check_eq("cyc_floor", floor, m_floor);
      check_eq("cyc_status", status, m_mode);
      check_eq("cyc_door_open", door_open, (m_mode == 7));
      check_eq("cyc_nextup", nextup, nu);
      check_eq("cyc_nextdown", nextdown, nd);
   endtask

   task automatic stim();
      int v, b;
      v = $urandom_range(0, 2);
      b = $urandom_range(0, 7);
      if ($urandom_range(0, 11) == 0) begin
         case (v)
            0: up[b] = 1'b1;
            1: down[b] = 1'b1;
            default: elevator_btn[b] = 1'b1;
         endcase
      end
      if ($urandom_range(0, 63) == 0) begin
         b = $urandom_range(0, 7);
         up[b] = 1'b0; down[b] = 1'b0; elevator_btn[b] = 1'b0;
      end
      if (m_mode == 7 && $urandom_range(0, 1) == 0) begin
         up[m_floor] = 1'b0; down[m_floor] = 1'b0; elevator_btn[m_floor] = 1'b0;
      end
`ifdef ELEVATOR_DOOR_REOPEN_EN
      door_btn = ($urandom_range(0, 39) == 0);
`endif
   endtask

   task automatic cycle(input bit rnd);
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      compare_outputs();
      if (rnd) stim();
   endtask

   task automatic wait_for(input string tag, input int mode, input int fl, input int budget,
                           output int k);
      k = 0;
      while (!(m_mode == mode && m_floor == fl) && k < budget) begin
         cycle(1'b0);
         k++;
      end
      if (k >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout after %0d cycles, model at status %0d floor %0d",
                  tag, k, m_mode, m_floor);
      end
      check_eq({tag, "_status"}, status, mode);
      check_eq({tag, "_floor"}, floor, fl);
   endtask

   task automatic async_reset_check(input string tag);
      rst = 1'b1;
      #1;
      check_eq({tag, "_floor"}, floor, 0);
      check_eq({tag, "_status"}, status, 0);
      check_eq({tag, "_nextup"}, nextup, 0);
      check_eq({tag, "_nextdown"}, nextdown, 0);
      check_eq({tag, "_door"}, door_open, 0);
      model_reset();
      cycle(1'b0);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int open_cnt;
      model_reset();
      #12;
      compare_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Travel 0 -> 5 on a car call.
      elevator_btn = 8'h20;
      cycle(1'b0);
      check_eq("r16_start", status, 1);
      repeat (5 * FC) cycle(1'b0);
      check_eq("r16_floor", floor, 5);
      check_eq("r16_svc", status, 7);
      check_eq("r16_nu", nextup, 0);
      check_eq("r16_nd", nextdown, 0);
      elevator_btn = 8'h00;
      repeat (DC - 1) cycle(1'b0);
      check_eq("r16_door_held", door_open, 1);
      cycle(1'b0);
      check_eq("r16_close", status, 8);
      cycle(1'b0);
      check_eq("r16_idle", status, 0);

      // Up sweep from 2 skips a down call at 4, then picks it up on the way back.
      elevator_btn = 8'h04;
      wait_for("r17_at2", 7, 2, 100, k);
      elevator_btn = 8'h00;
      wait_for("r17_idle2", 0, 2, 50, k);
      elevator_btn = 8'h40;
      down = 8'h10;
      cycle(1'b0);
      check_eq("r17_moveup", status, 1);
      wait_for("r17_at6", 7, 6, 200, k);
      check_eq("r17_travel", k, 4 * FC);
      check_eq("r17_nd", nextdown, 1);
      check_eq("r17_nu", nextup, 0);
      elevator_btn = 8'h00;
      wait_for("r17_at4", 7, 4, 200, k);
      check_eq("r17_back", k, DC + 1 + 2 * FC);
      down = 8'h00;
      wait_for("r17_idle", 0, 4, 50, k);

      // Hall call at the idle car's own floor.
      elevator_btn = 8'h08;
      wait_for("r18_at3", 7, 3, 100, k);
      elevator_btn = 8'h00;
      wait_for("r18_idle3", 0, 3, 50, k);
      up = 8'h08;
      cycle(1'b0);
      check_eq("r18_svc", status, 7);
      check_eq("r18_floor", floor, 3);
      up = 8'h00;
      wait_for("r18_idle", 0, 3, 50, k);

      // Top floor, then all the way down.
      elevator_btn = 8'h80;
      wait_for("r20_at7", 7, 7, 200, k);
      down = 8'h01;
      elevator_btn = 8'h00;
      #1;
      check_eq("r20_nd", nextdown, 1);
      wait_for("r20_close", 8, 7, 50, k);
      cycle(1'b0);
      check_eq("r20_movedown", status, 2);
      wait_for("r20_at0", 7, 0, 200, k);

`ifdef ELEVATOR_DOOR_REOPEN_EN
      cycle(1'b0);
      cycle(1'b0);
      door_btn = 1'b1;
      cycle(1'b0);
      door_btn = 1'b0;
      down = 8'h00;
      open_cnt = 4;
      for (int i = 0; i < 3 * DC; i++) begin
         cycle(1'b0);
         if (door_open) open_cnt++;
         else break;
      end
      check_eq("r21_open_cycles", open_cnt, 3 + DC);
`else
      down = 8'h00;
      open_cnt = 0;
`endif
      wait_for("r20_idle", 0, 0, 50, k);

      // Asynchronous reset while travelling 3 -> 4.
      elevator_btn = 8'h10;
      wait_for("r19_at3", 1, 3, 200, k);
      repeat (FC / 2) cycle(1'b0);
      elevator_btn = 8'h00;
      async_reset_check("r19_rst");

      for (int i = 0; i < 4000; i++) begin
         cycle(1'b1);
         if (i % 900 == 450) async_reset_check("rnd_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  FLOOR_CYCLES, 200, clock cycles to travel one floor
  DOOR_CYCLES, 100, clock cycles the door stays open
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  input  1  single system clock, all state on rising edge
  rst  input  1  asynchronous, active-high reset
  up  input  8  registered hall up-call vector, bit n = floor n
  down  input  8  registered hall down-call vector
  elevator_btn  input  8  registered car-call vector
  door_btn  input  1  door-reopen request (present only with DOOR_REOPEN_EN)
  floor  output  3  current floor, 0..7
  status  output  4  FSM state code
  nextup  output  1  direction after current service is up
  nextdown  output  1  direction after current service is down
  door_open  output  1  high while status==7

Function
REQ-003 Status codes SHALL be: 0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 7 SERVICE, 8 CLOSE; no other codes are driven.
REQ-004 Definitions: req = up|down|elevator_btn; here = req[floor]; above = |req[7:floor+1]; below = |req[floor-1:0] (above=0 at floor 7, below=0 at floor 0).
REQ-005 IDLE: here -> SERVICE; else above -> MOVE_UP, dir=up; else below -> MOVE_DOWN, dir=down; else stay; decision one cycle after request visibility.
REQ-006 MOVE_UP/MOVE_DOWN: a travel counter SHALL run 0..FLOOR_CYCLES-1; at terminal count floor +/-1 and the counter clears.
REQ-007 On arrival at f going up: stop (SERVICE) if elevator_btn[f] | up[f]; else if no requests above f: SERVICE if here, else IDLE; else continue. Mirror for down with down[f].
REQ-008 floor SHALL never be driven past 7 or below 0; reaching floor 7 up or floor 0 down always exits the move state per REQ-007.
REQ-009 SERVICE SHALL last exactly DOOR_CYCLES cycles, then CLOSE for exactly one cycle.
REQ-010 During SERVICE only: dir up -> nextup=above, nextdown=~above&below; dir down -> nextdown=below, nextup=~below&above; both 0 otherwise and outside SERVICE.
REQ-011 CLOSE: dir up & above -> MOVE_UP; dir down & below -> MOVE_DOWN; else below -> MOVE_DOWN; else above -> MOVE_UP; else here -> SERVICE; else IDLE; dir updated to match.
REQ-012 Request vectors changing mid-move SHALL be honoured at the next arrival evaluation; requests vanishing mid-move do not abort travel of the current floor.

Reset
REQ-013 rst high SHALL immediately force floor=0, status=0, nextup=0, nextdown=0, door_open=0, dir=up, all counters 0, including mid-move or mid-service.
REQ-014 First state evaluation SHALL occur on the first rising clk edge after rst deasserts.

Configuration
REQ-015 Macro ELEVATOR_DOOR_REOPEN_EN: when defined, door_btn exists and door_btn high in SERVICE or CLOSE SHALL restart a full DOOR_CYCLES SERVICE period; when undefined, the port is absent and SERVICE duration is fixed.

Verification
REQ-016 Reset at floor 0, elevator_btn=8'h20 -> MOVE_UP, floor reaches 5 after 5*FLOOR_CYCLES cycles, status 7 for DOOR_CYCLES, nextup=nextdown=0.
REQ-017 Car at 2 moving up, down=8'h10, elevator_btn=8'h40 -> passes floor 4 without stopping, services 6 (nextdown=1), then services 4 on the way down.
REQ-018 Car at 3 idle, up=8'h08 -> status 7 one cycle later, no floor change.
REQ-019 rst pulsed mid-travel between floors 3 and 4 -> outputs return to reset values asynchronously, before the next clk edge.
REQ-020 Car at 7 with elevator_btn=8'h80 and down=8'h01 -> floor never exceeds 7; after CLOSE goes MOVE_DOWN to 0.
REQ-021 With ELEVATOR_DOOR_REOPEN_EN, door_btn pulsed at SERVICE cycle 90 -> door_open stays high 90+DOOR_CYCLES cycles total.
